// File: rtl/rgb_hue_sequencer.sv
// rtl/rgb_hue_sequencer.sv - six-phase RGB hue wheel sequencer with compare-based PWM outputs
module rgb_hue_sequencer #(
    parameter int MAX_DUTY = 10,
    parameter int HOLD     = 4,
    parameter int W        = 4
) (
    input  logic         CLK,
    input  logic         CLR_N,
    input  logic         CE_IN,
    input  logic         EN,
    input  logic         DIR_CNT,
    output logic [W-1:0] DUTY_R,
    output logic [W-1:0] DUTY_G,
    output logic [W-1:0] DUTY_B,
    output logic [2:0]   PHASE,
    output logic         STEP_PULSE,
    output logic         LED_R,
    output logic         LED_G,
    output logic         LED_B
);

    localparam int            HW       = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [W-1:0]  FULL     = W'(MAX_DUTY);
    localparam logic [W-1:0]  TOP      = W'(MAX_DUTY - 1);
    localparam logic [HW-1:0] HOLD_TOP = HW'(HOLD - 1);

    typedef enum logic [2:0] {
        PH_RED     = 3'd0,
        PH_YELLOW  = 3'd1,
        PH_GREEN   = 3'd2,
        PH_CYAN    = 3'd3,
        PH_BLUE    = 3'd4,
        PH_MAGENTA = 3'd5
    } phase_t;

    phase_t        phase, phase_nxt;
    logic [W-1:0]  slot;
    logic [W-1:0]  level, level_nxt;
    logic [HW-1:0] hold;
    logic          period_end;
    logic          step;
    logic [W-1:0]  up, dn;
    logic [W-1:0]  duty_r_nxt, duty_g_nxt, duty_b_nxt;

    assign PHASE = phase;

    // Step fires on the last slot of the last held period; EN gates the hold count only
    always_comb begin
        period_end = CE_IN && (slot == TOP);
        step       = period_end && EN && (hold == HOLD_TOP);
    end

    // Phase/level register: the hue wheel position
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            phase <= PH_RED;
            level <= '0;
        end else begin
            phase <= phase_nxt;
            level <= level_nxt;
        end
    end

    // Next wheel position: one level per step, crossing into the neighbouring phase at the ends
    always_comb begin
        phase_nxt = phase;
        level_nxt = level;
        if (step) begin
            if (!DIR_CNT) begin
                if (level == TOP) begin
                    level_nxt = '0;
                    case (phase)
                        PH_RED:     phase_nxt = PH_YELLOW;
                        PH_YELLOW:  phase_nxt = PH_GREEN;
                        PH_GREEN:   phase_nxt = PH_CYAN;
                        PH_CYAN:    phase_nxt = PH_BLUE;
                        PH_BLUE:    phase_nxt = PH_MAGENTA;
                        default:    phase_nxt = PH_RED;
                    endcase
                end else begin
                    level_nxt = level + 1'b1;
                end
            end else begin
                if (level == '0) begin
                    level_nxt = TOP;
                    case (phase)
                        PH_RED:     phase_nxt = PH_MAGENTA;
                        PH_YELLOW:  phase_nxt = PH_RED;
                        PH_GREEN:   phase_nxt = PH_YELLOW;
                        PH_CYAN:    phase_nxt = PH_GREEN;
                        PH_BLUE:    phase_nxt = PH_CYAN;
                        default:    phase_nxt = PH_BLUE;
                    endcase
                end else begin
                    level_nxt = level - 1'b1;
                end
            end
        end
    end

    // Duty mapping of the next position; rising channel follows level, falling channel its complement
    always_comb begin
        up         = level_nxt;
        dn         = FULL - level_nxt;
        duty_r_nxt = FULL;
        duty_g_nxt = '0;
        duty_b_nxt = '0;
        case (phase_nxt)
            PH_RED:     begin duty_r_nxt = FULL; duty_g_nxt = up;   duty_b_nxt = '0;   end
            PH_YELLOW:  begin duty_r_nxt = dn;   duty_g_nxt = FULL; duty_b_nxt = '0;   end
            PH_GREEN:   begin duty_r_nxt = '0;   duty_g_nxt = FULL; duty_b_nxt = up;   end
            PH_CYAN:    begin duty_r_nxt = '0;   duty_g_nxt = dn;   duty_b_nxt = FULL; end
            PH_BLUE:    begin duty_r_nxt = up;   duty_g_nxt = '0;   duty_b_nxt = FULL; end
            PH_MAGENTA: begin duty_r_nxt = FULL; duty_g_nxt = '0;   duty_b_nxt = dn;   end
            default:    begin duty_r_nxt = FULL; duty_g_nxt = '0;   duty_b_nxt = '0;   end
        endcase
    end

    // Slot and hold counters; duty changes only with a step, which always lands on the slot wrap
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            slot       <= '0;
            hold       <= '0;
            STEP_PULSE <= 1'b0;
            DUTY_R     <= FULL;
            DUTY_G     <= '0;
            DUTY_B     <= '0;
        end else begin
            if (CE_IN)
                slot <= (slot == TOP) ? '0 : slot + 1'b1;
            if (period_end && EN)
                hold <= (hold == HOLD_TOP) ? '0 : hold + 1'b1;
            STEP_PULSE <= step;
            DUTY_R     <= duty_r_nxt;
            DUTY_G     <= duty_g_nxt;
            DUTY_B     <= duty_b_nxt;
        end
    end

    // PWM compare outputs, one cycle behind the slot counter
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            LED_R <= 1'b0;
            LED_G <= 1'b0;
            LED_B <= 1'b0;
        end else begin
            LED_R <= EN && (slot < DUTY_R);
            LED_G <= EN && (slot < DUTY_G);
            LED_B <= EN && (slot < DUTY_B);
        end
    end

endmodule

// File: tb/tb_rgb_hue_sequencer.sv
// tb/tb_rgb_hue_sequencer.sv - scoreboard bench for rgb_hue_sequencer
module tb_rgb_hue_sequencer;

    typedef struct {
        int r;
        int g;
        int b;
        int ph;
    } exp_t;

    logic       CLK = 1'b0;
    logic       CLR_N = 1'b0;
    logic       CE_IN = 1'b1;
    logic       EN = 1'b1;
    logic       DIR_CNT = 1'b0;

    logic [3:0] d1_r, d1_g, d1_b, d2_r, d2_g, d2_b;
    logic [2:0] d1_ph, d2_ph;
    logic       d1_step, d2_step;
    logic       d1_lr, d1_lg, d1_lb, d2_lr, d2_lg, d2_lb;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   sc1 = 0, sc2 = 0, ls1 = -1, ls2 = -1;
    bit   mon1 = 0, mon2 = 0;
    exp_t q1[$];
    exp_t q2[$];

    always #5 CLK = ~CLK;

    rgb_hue_sequencer #(.MAX_DUTY(10), .HOLD(1), .W(4)) u1 (
        .CLK(CLK), .CLR_N(CLR_N), .CE_IN(CE_IN), .EN(EN), .DIR_CNT(DIR_CNT),
        .DUTY_R(d1_r), .DUTY_G(d1_g), .DUTY_B(d1_b), .PHASE(d1_ph),
        .STEP_PULSE(d1_step), .LED_R(d1_lr), .LED_G(d1_lg), .LED_B(d1_lb)
    );

    rgb_hue_sequencer #(.MAX_DUTY(10), .HOLD(2), .W(4)) u2 (
        .CLK(CLK), .CLR_N(CLR_N), .CE_IN(CE_IN), .EN(EN), .DIR_CNT(DIR_CNT),
        .DUTY_R(d2_r), .DUTY_G(d2_g), .DUTY_B(d2_b), .PHASE(d2_ph),
        .STEP_PULSE(d2_step), .LED_R(d2_lr), .LED_G(d2_lg), .LED_B(d2_lb)
    );

    function automatic int clamp10(int v);
        return (v < 0) ? 0 : ((v > 10) ? 10 : v);
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    // Colour at wheel position h (0..59), written as piecewise-linear hue curves
    function automatic exp_t model(int h);
        exp_t e;
        int   hh;
        hh   = ((h % 60) + 60) % 60;
        e.r  = clamp10(iabs(hh - 30) - 10);
        e.g  = clamp10(20 - iabs(hh - 20));
        e.b  = clamp10(20 - iabs(hh - 40));
        e.ph = hh / 10;
        return e;
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        CLR_N   = 1'b0;
        CE_IN   = 1'b1;
        EN      = 1'b1;
        DIR_CNT = 1'b0;
        @(negedge CLK);
        q1.delete();
        q2.delete();
        sc1 = 0; sc2 = 0; ls1 = -1; ls2 = -1;
        cyc = 0;
        CLR_N = 1'b1;
    endtask

    task automatic cycle();
        exp_t e;
        @(negedge CLK);
        cyc++;
        if (d1_step) begin
            sc1++;
            ls1 = cyc;
            if (mon1) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL u1_unexpected_step cycle %0d got step required none", cyc);
                end else begin
                    e = q1.pop_front();
                    if (int'(d1_r) !== e.r || int'(d1_g) !== e.g || int'(d1_b) !== e.b || int'(d1_ph) !== e.ph) begin
                        errors++;
                        $display("FAIL u1_step cycle %0d got (%0d,%0d,%0d) ph %0d required (%0d,%0d,%0d) ph %0d",
                                 cyc, d1_r, d1_g, d1_b, d1_ph, e.r, e.g, e.b, e.ph);
                    end
                end
            end
        end
        if (d2_step) begin
            sc2++;
            ls2 = cyc;
            if (mon2) begin
                checks++;
                if (q2.size() == 0) begin
                    errors++;
                    $display("FAIL u2_unexpected_step cycle %0d got step required none", cyc);
                end else begin
                    e = q2.pop_front();
                    if (int'(d2_r) !== e.r || int'(d2_g) !== e.g || int'(d2_b) !== e.b || int'(d2_ph) !== e.ph) begin
                        errors++;
                        $display("FAIL u2_step cycle %0d got (%0d,%0d,%0d) ph %0d required (%0d,%0d,%0d) ph %0d",
                                 cyc, d2_r, d2_g, d2_b, d2_ph, e.r, e.g, e.b, e.ph);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        mon1 = 0; mon2 = 0;
        repeat (2) @(negedge CLK);
        CLR_N = 1'b1;
        cyc = 0;
        repeat (25) cycle();
        #2 CLR_N = 1'b0;
        #1;
        checks++;
        if ({d1_r, d1_g, d1_b} !== {4'd10, 4'd0, 4'd0} || d1_ph !== 3'd0) begin
            errors++;
            $display("FAIL reset_u1_duty got (%0d,%0d,%0d) ph %0d required (10,0,0) ph 0", d1_r, d1_g, d1_b, d1_ph);
        end
        checks++;
        if ({d1_lr, d1_lg, d1_lb, d1_step} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_u1_leds got %b required 0000", {d1_lr, d1_lg, d1_lb, d1_step});
        end
        checks++;
        if ({d2_r, d2_g, d2_b} !== {4'd10, 4'd0, 4'd0} || d2_ph !== 3'd0 ||
            {d2_lr, d2_lg, d2_lb, d2_step} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_u2 got (%0d,%0d,%0d) ph %0d outs %b required (10,0,0) ph 0 outs 0000",
                     d2_r, d2_g, d2_b, d2_ph, {d2_lr, d2_lg, d2_lb, d2_step});
        end
    endtask

    task automatic test_first_step();
        int lg, lr;
        do_reset();
        mon1 = 0; mon2 = 1;
        q2.push_back(model(1));
        repeat (20) cycle();
        checks++;
        if (sc2 !== 1 || ls2 !== 20) begin
            errors++;
            $display("FAIL first_step got count %0d at cycle %0d required count 1 at cycle 20", sc2, ls2);
        end
        lg = 0; lr = 0;
        repeat (10) begin
            cycle();
            lg += int'(d2_lg);
            lr += int'(d2_lr);
        end
        checks++;
        if (lg !== 1 || lr !== 10) begin
            errors++;
            $display("FAIL first_period_pwm got G %0d R %0d required G 1 R 10", lg, lr);
        end
        checks++;
        if (sc2 !== 1 || q2.size() !== 0) begin
            errors++;
            $display("FAIL first_step_extra got count %0d pending %0d required 1 and 0", sc2, q2.size());
        end
    endtask

    task automatic test_full_wheel();
        int pr, pg, pb, diff, nch;
        do_reset();
        mon1 = 1; mon2 = 0;
        for (int h = 1; h <= 60; h++) q1.push_back(model(h));
        pr = 10; pg = 0; pb = 0;
        repeat (605) begin
            cycle();
            if (d1_step) begin
                nch  = int'(int'(d1_r) != pr) + int'(int'(d1_g) != pg) + int'(int'(d1_b) != pb);
                diff = iabs(int'(d1_r) - pr) + iabs(int'(d1_g) - pg) + iabs(int'(d1_b) - pb);
                checks++;
                if (nch !== 1 || diff !== 1 || (cyc % 10) !== 0) begin
                    errors++;
                    $display("FAIL wheel_single_change cycle %0d got channels %0d delta %0d required 1 and 1 on period end",
                             cyc, nch, diff);
                end
                pr = int'(d1_r); pg = int'(d1_g); pb = int'(d1_b);
            end
        end
        checks++;
        if (sc1 !== 60 || q1.size() !== 0) begin
            errors++;
            $display("FAIL wheel_count got %0d steps pending %0d required 60 and 0", sc1, q1.size());
        end
    endtask

    task automatic test_reverse();
        do_reset();
        mon1 = 1; mon2 = 0;
        DIR_CNT = 1'b1;
        q1.push_back(model(59));
        repeat (10) cycle();
        q1.push_back(model(58));
        repeat (10) cycle();
        DIR_CNT = 1'b0;
        q1.push_back(model(59));
        repeat (10) cycle();
        checks++;
        if (sc1 !== 3 || q1.size() !== 0) begin
            errors++;
            $display("FAIL reverse_count got %0d steps pending %0d required 3 and 0", sc1, q1.size());
        end
        checks++;
        if ({d1_r, d1_g, d1_b} !== {4'd10, 4'd0, 4'd1} || d1_ph !== 3'd5) begin
            errors++;
            $display("FAIL reverse_final got (%0d,%0d,%0d) ph %0d required (10,0,1) ph 5", d1_r, d1_g, d1_b, d1_ph);
        end
    endtask

    task automatic test_enable_hold();
        int leds;
        do_reset();
        mon1 = 0; mon2 = 1;
        repeat (10) cycle();
        EN = 1'b0;
        leds = 0;
        repeat (500) begin
            cycle();
            leds += int'(d2_lr) + int'(d2_lg) + int'(d2_lb);
        end
        checks++;
        if (sc2 !== 0 || leds !== 0) begin
            errors++;
            $display("FAIL disabled got steps %0d led highs %0d required 0 and 0", sc2, leds);
        end
        checks++;
        if ({d2_r, d2_g, d2_b} !== {4'd10, 4'd0, 4'd0} || d2_ph !== 3'd0) begin
            errors++;
            $display("FAIL disabled_duty got (%0d,%0d,%0d) ph %0d required (10,0,0) ph 0", d2_r, d2_g, d2_b, d2_ph);
        end
        EN = 1'b1;
        q2.push_back(model(1));
        repeat (15) cycle();
        checks++;
        if (sc2 !== 1 || ls2 !== 520 || q2.size() !== 0) begin
            errors++;
            $display("FAIL resume got count %0d at cycle %0d pending %0d required 1 at 520 pending 0",
                     sc2, ls2, q2.size());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        mon1 = 1; mon2 = 0;
        for (int h = 1; h <= 35; h++) q1.push_back(model(h));
        repeat (355) cycle();
        checks++;
        if (d1_ph !== 3'd3 || q1.size() !== 0) begin
            errors++;
            $display("FAIL pre_reset_phase got ph %0d pending %0d required ph 3 pending 0", d1_ph, q1.size());
        end
        #2 CLR_N = 1'b0;
        #1;
        checks++;
        if ({d1_r, d1_g, d1_b} !== {4'd10, 4'd0, 4'd0} || d1_ph !== 3'd0 ||
            {d1_lr, d1_lg, d1_lb, d1_step} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset got (%0d,%0d,%0d) ph %0d outs %b required (10,0,0) ph 0 outs 0000",
                     d1_r, d1_g, d1_b, d1_ph, {d1_lr, d1_lg, d1_lb, d1_step});
        end
        do_reset();
        q1.push_back(model(1));
        q1.push_back(model(2));
        repeat (22) cycle();
        checks++;
        if (sc1 !== 2 || q1.size() !== 0) begin
            errors++;
            $display("FAIL restart got %0d steps pending %0d required 2 and 0", sc1, q1.size());
        end
    endtask

    initial begin
        test_reset();
        test_first_step();
        test_full_wheel();
        test_reverse();
        test_enable_hold();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
